picorv32_mem_arbiter: RTL and testbench
=======================================

Name: picorv32_mem_arbiter

Overview:
- Shares one picorv32-style native memory port (valid/ready/addr/wdata/wstrb/rdata) between two requesters: port 0 is the core and port 1 is a loader/DMA/debug master.
- Sits between the masters and the single SRAM model (mem) in the simulation and FPGA top levels.
- Arbitration is round-robin or fixed-priority. Each grant is locked until the downstream handshake completes.
- A watchdog terminates any transaction that is never acknowledged.

Parameters:
- ROUND_ROBIN, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- TIMEOUT, 1024: cycles the downstream may take to acknowledge before the watchdog fires. 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned to the master on a watchdog abort.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_valid  in  1  port 0 request; held until m0_ready.
- m0_addr  in  32  port 0 address.
- m0_wdata  in  32  port 0 write data.
- m0_wstrb  in  4  port 0 byte strobes; 0 = read.
- m0_ready  out  1  port 0 completion, 1-cycle pulse.
- m0_rdata  out  32  port 0 read data, valid while m0_ready=1.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_ready, m1_rdata: same as port 0, for port 1.
- mem_valid  out  1  downstream request.
- mem_addr  out  32  downstream address, registered.
- mem_wdata  out  32  downstream write data, registered.
- mem_wstrb  out  4  downstream byte strobes, registered.
- mem_ready  in  1  downstream acknowledge.
- mem_rdata  in  32  downstream read data.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout  out  1  1-cycle pulse when the watchdog aborts a transaction.

Behaviour:
- Reset values: grant=00, mem_valid=0, mem_addr/mem_wdata/mem_wstrb=0, m0_ready=m1_ready=0, m0_rdata=m1_rdata=0, timeout=0. The round-robin pointer is set so that port 0 has priority. The watchdog counter is 0.
- States:
  - IDLE: mem_valid=0.
  - BUSY: mem_valid=1 with the latched request.
- IDLE -> BUSY: on the first cycle any mX_valid=1.
  - Winner selection: fixed mode always prefers port 0. Round-robin mode prefers the port that did not win the last grant.
  - On that edge, latch the winner's addr/wdata/wstrb into the mem_* registers, set grant, and clear the watchdog.
  - mem_valid rises the cycle after the request is first seen (1-cycle arbitration latency).
- BUSY -> IDLE on mem_ready=1:
  - The same cycle, combinationally, assert the owner's mX_ready=1 and pass mem_rdata to the owner's mX_rdata.
  - On the edge: grant=00, mem_valid=0, and the round-robin pointer moves to the other port.
- Back-to-back requests: there is at least one IDLE cycle between transactions. A master holding valid after its ready is treated as a new request.
- While not ready, mX_rdata=0. The losing port's ready stays 0 and its valid is ignored until arbitration.
- Masters must hold valid/addr/wdata/wstrb stable until ready. Only the values sampled at grant are used; later changes are ignored.
- Watchdog (TIMEOUT>0): increments every BUSY cycle with mem_ready=0. When the count reaches TIMEOUT-1 and mem_ready=0:
  - The owner gets mX_ready=1 with mX_rdata=ERR_RDATA, and timeout pulses for that cycle.
  - The FSM returns to IDLE and the pointer advances.
  - If mem_ready and the timeout coincide, mem_ready wins: normal completion, no timeout pulse.
- A mem_ready while IDLE is ignored.
- Reset mid-transaction: the state is abandoned on the next edge, all outputs return to reset values, and no ready is issued to the owner.
- A grant is never switched while BUSY. The arbiter never issues more than one mX_ready per grant.

Test Plan:
- Single read:
  - Stimulus: m0 read addr=0x100, mem returns 0x12345678 two cycles after mem_valid.
  - Response: mem_valid rises 1 cycle after m0_valid and mem_addr=0x100. m0_ready pulses once with rdata=0x12345678. grant goes 01 -> 00. m1_ready stays 0.
- Simultaneous requests, ROUND_ROBIN=1:
  - Stimulus: m0 and m1 request continuously, mem_ready one cycle after each mem_valid.
  - Response: grants alternate 01, 10, 01, 10. Each port sees exactly one ready per grant.
- Fixed priority, ROUND_ROBIN=0:
  - Stimulus: same stimulus as the round-robin case.
  - Response: port 0 is always granted. m1 is served only when m0_valid=0.
- Write stability:
  - Stimulus: m1 writes addr=0x20, wdata=0xA5A5A5A5, wstrb=0011, then changes addr during BUSY.
  - Response: mem_addr/mem_wdata/mem_wstrb stay 0x20/0xA5A5A5A5/0011 until mem_ready.
- Watchdog:
  - Stimulus: TIMEOUT=8, mem_ready held at 0.
  - Response: 8 BUSY cycles after mem_valid rises, the owner gets ready with rdata=0xDEADBEEF and timeout=1 for one cycle, then the FSM returns to IDLE. A repeat with mem_ready in cycle 8 gives normal data and no timeout pulse.
- Reset mid-operation:
  - Stimulus: assert reset while BUSY and mem_ready=0.
  - Response: next edge gives mem_valid=0, grant=00, no mX_ready pulse. After reset, port 0 wins the first simultaneous arbitration.

Source files
------------

// File: rtl/picorv32_mem_arbiter_if.sv
// picorv32 native memory port: valid/ready handshake with address, write data,
// byte strobes and read data. The master drives the request; the slave answers.
interface picorv32_mem_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picorv32_mem_arbiter.sv
// Two-master arbiter for one picorv32 native memory port. Port 0 is the core
// and port 1 is a loader/debug master. A watchdog aborts transactions the memory never acknowledges.
//
// state | meaning
// IDLE  | no owner, mem_valid=0, arbitrating any pending request
// BUSY  | owner latched in grant, mem_* registers hold its request
module picorv32_mem_arbiter #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 1024,
    parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
    input  logic                          clock,
    input  logic                          reset,
    picorv32_mem_arbiter_if.slave         m0,
    picorv32_mem_arbiter_if.slave         m1,
    picorv32_mem_arbiter_if.master        mem,
    output logic [1:0]                    grant,
    output logic                          timeout
);
    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit            WD_EN   = (TIMEOUT != 0);
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state;
    logic          last_win;
    logic [CW-1:0] wd_count;
    logic          req_any;
    logic          pick;
    logic          done_ok;
    logic          wd_fire;
    logic          finish;
    logic [31:0]   resp_data;

    always_comb begin
        req_any = m0.valid | m1.valid;
        pick    = 1'b0;
        if (m0.valid && m1.valid)
            pick = ROUND_ROBIN ? ~last_win : 1'b0;
        else
            pick = m1.valid;
    end

    // Completion responses are suppressed while reset is held so an abandoned
    // transaction never hands its owner a ready.
    assign done_ok   = (state == BUSY) && mem.ready && !reset;
    assign wd_fire   = WD_EN && (state == BUSY) && !mem.ready
                       && (wd_count == WD_LAST) && !reset;
    assign finish    = done_ok | wd_fire;
    assign resp_data = wd_fire ? ERR_RDATA : mem.rdata;

    assign m0.ready  = finish & grant[0];
    assign m1.ready  = finish & grant[1];
    assign m0.rdata  = m0.ready ? resp_data : 32'h0;
    assign m1.rdata  = m1.ready ? resp_data : 32'h0;
    assign timeout   = wd_fire;

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 2'b00;
            mem.valid <= 1'b0;
            mem.addr  <= 32'h0;
            mem.wdata <= 32'h0;
            mem.wstrb <= 4'h0;
            last_win  <= 1'b1;
            wd_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state     <= BUSY;
                        mem.valid <= 1'b1;
                        grant     <= pick ? 2'b10 : 2'b01;
                        mem.addr  <= pick ? m1.addr  : m0.addr;
                        mem.wdata <= pick ? m1.wdata : m0.wdata;
                        mem.wstrb <= pick ? m1.wstrb : m0.wstrb;
                        wd_count  <= '0;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        state     <= IDLE;
                        mem.valid <= 1'b0;
                        grant     <= 2'b00;
                        last_win  <= grant[1];
                    end else if (WD_EN) begin
                        wd_count  <= wd_count + CW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem.valid <= 1'b0;
                    grant     <= 2'b00;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: a round-robin and a fixed-priority instance,
// one active at a time, checked against a transaction-level arbitration model.
module tb_picorv32_mem_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    picorv32_mem_arbiter_if rr_m0 ();
    picorv32_mem_arbiter_if rr_m1 ();
    picorv32_mem_arbiter_if rr_mem ();
    picorv32_mem_arbiter_if fp_m0 ();
    picorv32_mem_arbiter_if fp_m1 ();
    picorv32_mem_arbiter_if fp_mem ();
    logic [1:0] rr_grant, fp_grant;
    logic       rr_timeout, fp_timeout;

    picorv32_mem_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(8), .ERR_RDATA(32'hDEAD_BEEF)) u_rr (
        .clock(clock), .reset(reset), .m0(rr_m0), .m1(rr_m1), .mem(rr_mem),
        .grant(rr_grant), .timeout(rr_timeout));
    picorv32_mem_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(8), .ERR_RDATA(32'hDEAD_BEEF)) u_fp (
        .clock(clock), .reset(reset), .m0(fp_m0), .m1(fp_m1), .mem(fp_mem),
        .grant(fp_grant), .timeout(fp_timeout));

    bit          sel;   // 0 drives the round-robin instance, 1 the fixed-priority one
    logic        m_valid [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [3:0]  m_wstrb [2];
    logic        mem_ready;
    logic [31:0] ram [256];

    assign rr_m0.valid = !sel && m_valid[0];
    assign rr_m1.valid = !sel && m_valid[1];
    assign fp_m0.valid = sel && m_valid[0];
    assign fp_m1.valid = sel && m_valid[1];
    assign rr_m0.addr  = m_addr[0];  assign rr_m1.addr  = m_addr[1];
    assign fp_m0.addr  = m_addr[0];  assign fp_m1.addr  = m_addr[1];
    assign rr_m0.wdata = m_wdata[0]; assign rr_m1.wdata = m_wdata[1];
    assign fp_m0.wdata = m_wdata[0]; assign fp_m1.wdata = m_wdata[1];
    assign rr_m0.wstrb = m_wstrb[0]; assign rr_m1.wstrb = m_wstrb[1];
    assign fp_m0.wstrb = m_wstrb[0]; assign fp_m1.wstrb = m_wstrb[1];
    assign rr_mem.ready = !sel && mem_ready;
    assign fp_mem.ready = sel && mem_ready;
    assign rr_mem.rdata = ram[rr_mem.addr[9:2]];
    assign fp_mem.rdata = ram[fp_mem.addr[9:2]];

    logic        obs_ready [2];
    logic [31:0] obs_rdata [2];
    logic        mem_valid_o, timeout_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic [1:0]  grant_o;
    assign obs_ready[0] = sel ? fp_m0.ready : rr_m0.ready;
    assign obs_ready[1] = sel ? fp_m1.ready : rr_m1.ready;
    assign obs_rdata[0] = sel ? fp_m0.rdata : rr_m0.rdata;
    assign obs_rdata[1] = sel ? fp_m1.rdata : rr_m1.rdata;
    assign mem_valid_o  = sel ? fp_mem.valid : rr_mem.valid;
    assign mem_addr_o   = sel ? fp_mem.addr  : rr_mem.addr;
    assign mem_wdata_o  = sel ? fp_mem.wdata : rr_mem.wdata;
    assign mem_wstrb_o  = sel ? fp_mem.wstrb : rr_mem.wstrb;
    assign grant_o      = sel ? fp_grant : rr_grant;
    assign timeout_o    = sel ? fp_timeout : rr_timeout;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int last_win = 1;   // model: previous winner; 1 after reset so port 0 is preferred

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic int pick_winner();
        if (m_valid[0] && !m_valid[1]) return 0;
        if (m_valid[1] && !m_valid[0]) return 1;
        if (sel) return 0;
        return (last_win == 0) ? 1 : 0;
    endfunction

    task automatic new_req(input int p);
        m_valid[p] = 1'b1;
        m_addr[p]  = $urandom & 32'h0000_03FC;
        m_wdata[p] = $urandom;
        m_wstrb[p] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        #1;
        chk("rst_grant", grant_o, 2'b00);
        chk("rst_mem_valid", mem_valid_o, 1'b0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        chk("rst_mem_wstrb", mem_wstrb_o, 4'h0);
        chk("rst_ready0", obs_ready[0], 1'b0);
        chk("rst_ready1", obs_ready[1], 1'b0);
        chk("rst_rdata0", obs_rdata[0], 32'h0);
        chk("rst_rdata1", obs_rdata[1], 32'h0);
        chk("rst_timeout", timeout_o, 1'b0);
        reset = 1'b0;
        last_win = 1;
    endtask

    // One arbitration round: memory acknowledges in busy cycle lat+1; with
    // TIMEOUT=8 a transaction still unacknowledged in busy cycle 8 is aborted.
    task automatic txn(input int lat, input bit scramble);
        int          w;
        logic [31:0] ea, ed;
        logic [3:0]  es;
        bit          done;
        #1;
        chk("req_mem_valid", mem_valid_o, 1'b0);
        chk("req_grant", grant_o, 2'b00);
        chk("req_ready0", obs_ready[0], 1'b0);
        chk("req_ready1", obs_ready[1], 1'b0);
        w  = pick_winner();
        ea = m_addr[w];
        ed = m_wdata[w];
        es = m_wstrb[w];
        done = 1'b0;
        step();
        if (scramble) begin
            m_addr[w]  = $urandom;
            m_wdata[w] = $urandom;
            m_wstrb[w] = 4'($urandom);
        end
        for (int c = 1; c <= 8 && !done; c++) begin
            mem_ready = (c == lat + 1);
            #1;
            chk("busy_valid", mem_valid_o, 1'b1);
            chk("busy_grant", grant_o, (w == 0) ? 2'b01 : 2'b10);
            chk("busy_addr", mem_addr_o, ea);
            chk("busy_wdata", mem_wdata_o, ed);
            chk("busy_wstrb", mem_wstrb_o, es);
            chk("loser_ready", obs_ready[1-w], 1'b0);
            chk("loser_rdata", obs_rdata[1-w], 32'h0);
            if (mem_ready) begin
                chk("done_ready", obs_ready[w], 1'b1);
                chk("done_rdata", obs_rdata[w], ram[ea[9:2]]);
                chk("done_timeout", timeout_o, 1'b0);
                done = 1'b1;
            end else if (c == 8) begin
                chk("wd_ready", obs_ready[w], 1'b1);
                chk("wd_rdata", obs_rdata[w], 32'hDEAD_BEEF);
                chk("wd_timeout", timeout_o, 1'b1);
                done = 1'b1;
            end else begin
                chk("wait_ready", obs_ready[w], 1'b0);
                chk("wait_rdata", obs_rdata[w], 32'h0);
                chk("wait_timeout", timeout_o, 1'b0);
                step();
            end
        end
        step();
        mem_ready  = 1'b0;
        m_valid[w] = 1'b0;
        last_win   = w;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = $urandom;
        ram[64] = 32'h1234_5678;
        sel = 1'b0;
        mem_ready = 1'b0;
        for (int p = 0; p < 2; p++) begin
            m_valid[p] = 1'b0; m_addr[p] = 32'h0; m_wdata[p] = 32'h0; m_wstrb[p] = 4'h0;
        end
        do_reset();

        // single read from port 0
        m_valid[0] = 1'b1; m_addr[0] = 32'h100; m_wdata[0] = 32'h0; m_wstrb[0] = 4'h0;
        txn(2, 1'b0);

        // continuous requests from both ports alternate under round-robin
        new_req(0); new_req(1);
        for (int i = 0; i < 6; i++) begin
            txn(1, 1'b0);
            new_req(last_win);
        end
        txn(1, 1'b0);
        txn(1, 1'b0);

        // port 1 write; request changes while busy must not reach the memory
        m_valid[1] = 1'b1; m_addr[1] = 32'h20; m_wdata[1] = 32'hA5A5_A5A5; m_wstrb[1] = 4'b0011;
        txn(3, 1'b1);

        // watchdog abort, then acknowledge coinciding with the final cycle
        new_req(0);
        txn(12, 1'b0);
        new_req(1);
        txn(7, 1'b0);

        // stray acknowledge while idle
        mem_ready = 1'b1;
        #1;
        chk("idle_ack_ready0", obs_ready[0], 1'b0);
        chk("idle_ack_ready1", obs_ready[1], 1'b0);
        step();
        chk("idle_ack_valid", mem_valid_o, 1'b0);
        chk("idle_ack_grant", grant_o, 2'b00);
        mem_ready = 1'b0;

        // reset while busy abandons the transaction without a ready
        m_valid[1] = 1'b1; m_addr[1] = 32'h44;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("midrst_ready1", obs_ready[1], 1'b0);
        step();
        chk("midrst_valid", mem_valid_o, 1'b0);
        chk("midrst_grant", grant_o, 2'b00);
        chk("midrst_ready0", obs_ready[0], 1'b0);
        chk("midrst_ready1b", obs_ready[1], 1'b0);
        reset = 1'b0;
        last_win = 1;
        m_valid[1] = 1'b0;
        new_req(0); new_req(1);
        txn(1, 1'b0);
        chk("post_rst_winner", last_win, 0);

        // randomized round-robin traffic
        for (int i = 0; i < 40; i++) begin
            for (int p = 0; p < 2; p++)
                if (!m_valid[p] && $urandom_range(0, 2) != 0) new_req(p);
            if (!m_valid[0] && !m_valid[1]) new_req(int'($urandom_range(0, 1)));
            txn(int'($urandom_range(0, 9)), $urandom_range(0, 3) == 0);
        end
        while (m_valid[0] || m_valid[1]) txn(int'($urandom_range(0, 3)), 1'b0);

        // fixed-priority instance
        sel = 1'b1;
        do_reset();
        new_req(0); new_req(1);
        for (int i = 0; i < 4; i++) begin
            txn(1, 1'b0);
            if (i < 3) new_req(0);
        end
        txn(1, 1'b0);
        chk("fp_port1_served", last_win, 1);
        for (int i = 0; i < 30; i++) begin
            for (int p = 0; p < 2; p++)
                if (!m_valid[p] && $urandom_range(0, 2) != 0) new_req(p);
            if (!m_valid[0] && !m_valid[1]) new_req(int'($urandom_range(0, 1)));
            txn(int'($urandom_range(0, 9)), $urandom_range(0, 3) == 0);
        end
        while (m_valid[0] || m_valid[1]) txn(int'($urandom_range(0, 3)), 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
